// File: rtl/rssb_pkg.sv
// Shared types and defaults for the RSSB sequencer: state encoding, halt address
// and the operand address that aliases the program counter.
package rssb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_UPDATE,
        S_HALT,
        S_PAUSE
    } state_t;

    // Truncated to ADDR_W by the user, so any width gets an all-ones halt address
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'hFFFF_FFFF;
    localparam int          PC_ALIAS_ADDR     = 0;

endpackage

// File: rtl/rssb_fsm.sv
// RSSB instruction sequencer state machine: state register plus next-state and
// memory-request decode. RSSB_STEP_EN adds a step input and the PAUSE state.
module rssb_fsm
    import rssb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   run,
`ifdef RSSB_STEP_EN
    input  logic   step,
`endif
    input  logic   mem_ready,
    input  logic   fetch_halt,
    input  logic   fetch_zero,
    input  logic   ir_zero,
    output state_t state,
    output logic   mem_req,
    output logic   mem_we,
    output logic   busy,
    output logic   halted
);

    state_t next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Requests decode straight from state so reset drops them asynchronously
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if (fetch_halt)      next_state = S_HALT;
                    else if (fetch_zero) next_state = S_EXEC;
                    else                 next_state = S_READ;
                end
            end
            S_READ: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = S_EXEC;
            end
            S_EXEC: next_state = ir_zero ? S_UPDATE : S_WRITE;
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) next_state = S_UPDATE;
            end
            S_UPDATE: begin
`ifdef RSSB_STEP_EN
                next_state = run ? S_PAUSE : S_IDLE;
`else
                next_state = run ? S_FETCH : S_IDLE;
`endif
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_PAUSE: begin
                busy = 1'b0;
`ifdef RSSB_STEP_EN
                if (!run)      next_state = S_IDLE;
                else if (step) next_state = S_FETCH;
`else
                next_state = S_IDLE;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/rssb_ctrl.sv
// RSSB one-instruction processor sequencer: PC, accumulator and operand registers
// around rssb_fsm. Optional single-step mode is enabled by defining RSSB_STEP_EN.
module rssb_ctrl
    import rssb_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef RSSB_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              halted,
    output logic [WIDTH-1:0]  acc,
    output logic [ADDR_W-1:0] pc
);

    state_t            state;
    logic [ADDR_W-1:0] ir;
    logic [WIDTH-1:0]  md;
    logic [WIDTH-1:0]  res;
    logic              brw;

    logic [ADDR_W-1:0] fetch_word;
    logic              ir_zero;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  result;
    logic              borrow;
    logic [ADDR_W-1:0] base;

    assign fetch_word = mem_rdata[ADDR_W-1:0];
    assign ir_zero    = (ir == ADDR_W'(PC_ALIAS_ADDR));

    rssb_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
`ifdef RSSB_STEP_EN
        .step       (step),
`endif
        .mem_ready  (mem_ready),
        .fetch_halt (fetch_word == HALT_ADDR),
        .fetch_zero (fetch_word == ADDR_W'(PC_ALIAS_ADDR)),
        .ir_zero    (ir_zero),
        .state      (state),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .busy       (busy),
        .halted     (halted)
    );

    // Address 0 reads back as the PC; a zero operand address also turns UPDATE into a jump
    always_comb begin
        operand = ir_zero ? WIDTH'(pc) : md;
        result  = operand - acc;
        borrow  = $signed(operand) < $signed(acc);
        base    = ir_zero ? res[ADDR_W-1:0] : pc;
    end

    // pc and ir cannot change while a request is pending, so address and data stay stable
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_FETCH: mem_addr = pc;
            S_READ:  mem_addr = ir;
            S_WRITE: begin
                mem_addr  = ir;
                mem_wdata = res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= PC_RESET;
            acc <= '0;
            ir  <= '0;
            md  <= '0;
            res <= '0;
            brw <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) ir <= fetch_word;
                S_READ:  if (mem_ready) md <= mem_rdata;
                S_EXEC: begin
                    acc <= result;
                    res <= result;
                    brw <= borrow;
                end
                S_UPDATE: pc <= base + ADDR_W'(brw ? 2 : 1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rssb_ctrl.sv
// Self-checking bench for rssb_ctrl: directed program from reset plus randomized
// programs and memory stalls checked against an instruction-level reference model.
module tb_rssb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       busy;
    logic       halted;
    logic [7:0] acc;
    logic [7:0] pc;
`ifdef RSSB_STEP_EN
    logic       step = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rssb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
`ifdef RSSB_STEP_EN
        .step      (step),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .halted    (halted),
        .acc       (acc),
        .pc        (pc)
    );

    // Unified memory: bench preloads through poke, the DUT writes through its port
    logic [7:0] mem [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;
    int         write_count = 0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            write_count   <= write_count + 1;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // Instruction-level reference machine
    logic [7:0] ref_mem [256];
    int         ref_pc;
    int         ref_acc;
    bit         ref_halted;

    task automatic ref_step(output int waddr);
        int a, op, r, sop, sacc;
        waddr = -1;
        a = int'(ref_mem[ref_pc]);
        if (a == 255) begin
            ref_halted = 1'b1;
            return;
        end
        op   = (a == 0) ? ref_pc : int'(ref_mem[a]);
        sop  = (op >= 128) ? op - 256 : op;
        sacc = (ref_acc >= 128) ? ref_acc - 256 : ref_acc;
        r    = (op - ref_acc + 256) % 256;
        ref_acc = r;
        if (a != 0) begin
            ref_mem[a] = 8'(r);
            waddr = a;
        end
        ref_pc = (((a == 0) ? r : ref_pc) + 1 + ((sop < sacc) ? 1 : 0)) % 256;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_pc     = 1;
        ref_acc    = 0;
        ref_halted = 1'b0;
    endtask

    // Runs one instruction from IDLE; mode 0 always ready, 1 random ready, 2 three READ stalls
    task automatic step_instr(input int mode, output int cycles);
        int         guard;
        int         stalls;
        logic       stalled;
        logic [7:0] sa, sd;
        logic       sw;
        cycles = 0; guard = 0; stalls = 0; stalled = 1'b0;
        sa = 8'h00; sd = 8'h00; sw = 1'b0;
        mem_ready = 1'b1;
        run = 1'b1;
        @(posedge clk);
        #2;
        run = 1'b0;
        forever begin
            if (mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (mem_req && !mem_we && mem_addr != pc && stalls < 3) begin
                    mem_ready = 1'b0;
                    stalls++;
                end else mem_ready = 1'b1;
            end
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (!mem_req || mem_addr !== sa || mem_we !== sw || mem_wdata !== sd) begin
                    failures++;
                    $display("[TB] FAIL req_stable: got req=%b addr=%h we=%b wdata=%h required req=1 addr=%h we=%b wdata=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, sa, sw, sd);
                end
            end
            if (!busy) break;
            cycles++;
            stalled = mem_req && !mem_ready;
            sa = mem_addr; sw = mem_we; sd = mem_wdata;
            guard++;
            if (guard > 300) begin
                checks++;
                failures++;
                $display("[TB] FAIL step_timeout: got busy after %0d cycles required idle", guard);
                break;
            end
            @(posedge clk);
            #2;
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (pc !== 8'h01)     begin failures++; $display("[TB] FAIL reset_pc: got %h required 01", pc); end
        if (acc !== 8'h00)    begin failures++; $display("[TB] FAIL reset_acc: got %h required 00", acc); end
        if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b required 0", mem_req); end
        if (mem_we !== 1'b0)  begin failures++; $display("[TB] FAIL reset_we: got %b required 0", mem_we); end
        if (mem_addr !== 8'h00)  begin failures++; $display("[TB] FAIL reset_addr: got %h required 00", mem_addr); end
        if (mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_wdata: got %h required 00", mem_wdata); end
        if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        if (halted !== 1'b0)  begin failures++; $display("[TB] FAIL reset_halted: got %b required 0", halted); end
    endtask

    task automatic test_reset_in_write();
        int  wc;
        bit  found;
        apply_reset();
        poke(8'h01, 8'h10);
        poke(8'h10, 8'h07);
        wc = write_count;
        found = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
        end
        run = 1'b0;
        checks++;
        if (!found) begin failures++; $display("[TB] FAIL reach_write: got no write request required one within 20 cycles"); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rstw_req: got %b required 0", mem_req); end
        if (mem_we !== 1'b0)  begin failures++; $display("[TB] FAIL rstw_we: got %b required 0", mem_we); end
        if (pc !== 8'h01)     begin failures++; $display("[TB] FAIL rstw_pc: got %h required 01", pc); end
        if (acc !== 8'h00)    begin failures++; $display("[TB] FAIL rstw_acc: got %h required 00", acc); end
        if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL rstw_busy: got %b required 0", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (write_count !== wc) begin failures++; $display("[TB] FAIL rstw_nowrite: got %0d writes required %0d", write_count, wc); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_program();
        int cyc, wc, reqs;
        apply_reset();
        poke(8'h01, 8'h10);
        poke(8'h10, 8'h05);
        poke(8'h02, 8'h11);
        poke(8'h11, 8'h03);
        poke(8'h04, 8'h00);
        poke(8'h07, 8'hFF);

        step_instr(0, cyc);
        checks += 4;
        if (acc !== 8'h05)      begin failures++; $display("[TB] FAIL nobrw_acc: got %h required 05", acc); end
        if (pc !== 8'h02)       begin failures++; $display("[TB] FAIL nobrw_pc: got %h required 02", pc); end
        if (mem[8'h10] !== 8'h05) begin failures++; $display("[TB] FAIL nobrw_mem: got %h required 05", mem[8'h10]); end
        if (cyc != 5)           begin failures++; $display("[TB] FAIL nobrw_cycles: got %0d required 5", cyc); end

        step_instr(0, cyc);
        checks += 4;
        if (acc !== 8'hFE)      begin failures++; $display("[TB] FAIL brw_acc: got %h required fe", acc); end
        if (pc !== 8'h04)       begin failures++; $display("[TB] FAIL brw_pc: got %h required 04", pc); end
        if (mem[8'h11] !== 8'hFE) begin failures++; $display("[TB] FAIL brw_mem: got %h required fe", mem[8'h11]); end
        if (cyc != 5)           begin failures++; $display("[TB] FAIL brw_cycles: got %0d required 5", cyc); end

        wc = write_count;
        step_instr(0, cyc);
        checks += 4;
        if (acc !== 8'h06)      begin failures++; $display("[TB] FAIL alias_acc: got %h required 06", acc); end
        if (pc !== 8'h07)       begin failures++; $display("[TB] FAIL alias_pc: got %h required 07", pc); end
        if (write_count != wc)  begin failures++; $display("[TB] FAIL alias_nowrite: got %0d writes required %0d", write_count, wc); end
        if (cyc != 3)           begin failures++; $display("[TB] FAIL alias_cycles: got %0d required 3", cyc); end

        step_instr(0, cyc);
        checks += 3;
        if (cyc != 1)           begin failures++; $display("[TB] FAIL halt_cycles: got %0d required 1", cyc); end
        if (halted !== 1'b1)    begin failures++; $display("[TB] FAIL halt_flag: got %b required 1", halted); end
        if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL halt_busy: got %b required 0", busy); end
        reqs = 0;
        run = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        run = 1'b0;
        checks += 3;
        if (reqs != 0)          begin failures++; $display("[TB] FAIL halt_noreq: got %0d requests required 0", reqs); end
        if (halted !== 1'b1)    begin failures++; $display("[TB] FAIL halt_sticky: got %b required 1", halted); end
        if (pc !== 8'h07)       begin failures++; $display("[TB] FAIL halt_pc: got %h required 07", pc); end
    endtask

    task automatic test_wait_states();
        int cyc;
        apply_reset();
        poke(8'h01, 8'h10);
        poke(8'h10, 8'h05);
        step_instr(2, cyc);
        checks += 4;
        if (cyc != 8)           begin failures++; $display("[TB] FAIL wait_cycles: got %0d required 8", cyc); end
        if (acc !== 8'h05)      begin failures++; $display("[TB] FAIL wait_acc: got %h required 05", acc); end
        if (pc !== 8'h02)       begin failures++; $display("[TB] FAIL wait_pc: got %h required 02", pc); end
        if (mem[8'h10] !== 8'h05) begin failures++; $display("[TB] FAIL wait_mem: got %h required 05", mem[8'h10]); end
    endtask

    task automatic test_random();
        int cyc, waddr, diffs;
        logic [7:0] v;
        for (int round = 0; round < 3; round++) begin
            apply_reset();
            for (int a = 0; a < 256; a++) begin
                v = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom);
                ref_mem[a] = v;
                poke(8'(a), v);
            end
            for (int n = 0; n < 40; n++) begin
                step_instr(1, cyc);
                ref_step(waddr);
                checks += 3;
                if (halted !== ref_halted) begin failures++; $display("[TB] FAIL rand_halted: got %b required %b", halted, ref_halted); end
                if (pc !== 8'(ref_pc))     begin failures++; $display("[TB] FAIL rand_pc: got %h required %h", pc, 8'(ref_pc)); end
                if (acc !== 8'(ref_acc))   begin failures++; $display("[TB] FAIL rand_acc: got %h required %h", acc, 8'(ref_acc)); end
                if (waddr >= 0) begin
                    checks++;
                    if (mem[waddr] !== ref_mem[waddr]) begin
                        failures++;
                        $display("[TB] FAIL rand_mem: addr %h got %h required %h", 8'(waddr), mem[waddr], ref_mem[waddr]);
                    end
                end
                if (ref_halted) apply_reset();
            end
            diffs = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) diffs++;
            checks++;
            if (diffs != 0) begin failures++; $display("[TB] FAIL rand_memimage: got %0d differing words required 0", diffs); end
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b1;
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
        test_reset();
        test_reset_in_write();
        test_program();
        test_wait_states();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
